// File: rtl/kbd_pkg.sv
// Shared register map, STATUS/CTRL bit positions and the STATUS word packer
// for the keyboard receive FIFO.
package kbd_pkg;

    typedef enum logic [1:0] {
        KBD_DATA   = 2'd0,
        KBD_STATUS = 2'd1,
        KBD_CTRL   = 2'd2,
        KBD_RSVD   = 2'd3
    } kbd_reg_e;

    localparam int ST_EMPTY   = 0;
    localparam int ST_FULL    = 1;
    localparam int ST_CNT_LSB = 2;
    localparam int ST_CNT_W   = 7;
    localparam int ST_IRQEN   = 14;
    localparam int ST_OVF     = 15;

    localparam int CT_FLUSH   = 0;
    localparam int CT_CLROVF  = 1;
    localparam int CT_IRQEN   = 2;

    localparam int DATA_VALID = 31;

    function automatic logic [31:0] kbd_status(
        input logic                empty,
        input logic                full,
        input logic [ST_CNT_W-1:0] count,
        input logic                irq_en,
        input logic                ovf
    );
        logic [31:0] s;
        s                            = '0;
        s[ST_EMPTY]                  = empty;
        s[ST_FULL]                   = full;
        s[ST_CNT_LSB +: ST_CNT_W]    = count;
        s[ST_IRQEN]                  = irq_en;
        s[ST_OVF]                    = ovf;
        return s;
    endfunction

endpackage

// File: rtl/kbd_fifo_mem.sv
// DEPTH x 8 character store: one synchronous write port, one asynchronous read
// port so the head character is available in the same cycle as the DATA read.
module kbd_fifo_mem #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [7:0]    wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [7:0]    rdata_o
);

    logic [7:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/kbd_rx_fifo.sv
// Keyboard receive FIFO with DATA/STATUS/CTRL bus registers.
// Optional level interrupt is built only when KBD_IRQ_EN is defined.
module kbd_rx_fifo
    import kbd_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        KeyValid,
    input  logic [7:0]  KeyAscii,
    input  logic        Sel,
    input  logic        We,
    input  logic [1:0]  Addr,
    input  logic [31:0] WData,
    output logic [31:0] RData,
    output logic        Irq
);

    logic [AW:0]  wr_ptr_q, wr_ptr_d;
    logic [AW:0]  rd_ptr_q, rd_ptr_d;
    logic [AW:0]  count;
    logic         ovf_q, ovf_d;
    logic [31:0]  rdata_q, rdata_d;
    logic         empty, full;
    logic         key_ok, rd_sel, wr_ctrl;
    logic         pop, push, drop, flush, clr_ovf;
    logic         irq_en;
    logic [7:0]   head;

    kbd_fifo_mem #(
        .DEPTH(DEPTH),
        .AW   (AW)
    ) u_mem (
        .clk_i  (CLK),
        .we_i   (push),
        .waddr_i(wr_ptr_q[AW-1:0]),
        .wdata_i(KeyAscii),
        .raddr_i(rd_ptr_q[AW-1:0]),
        .rdata_o(head)
    );

    // Pointers carry one extra wrap bit so DEPTH entries is distinguishable from empty.
    assign count = wr_ptr_q - rd_ptr_q;
    assign empty = (count == '0);
    assign full  = (count == (AW+1)'(DEPTH));

    always_comb begin
        key_ok   = KeyValid && (KeyAscii != 8'h00);
        rd_sel   = Sel && !We;
        wr_ctrl  = Sel && We && (kbd_reg_e'(Addr) == KBD_CTRL);
        flush    = wr_ctrl && WData[CT_FLUSH];
        clr_ovf  = wr_ctrl && WData[CT_CLROVF];
        pop      = rd_sel && (kbd_reg_e'(Addr) == KBD_DATA) && !empty;
        // A pop in the same cycle frees a slot, so a full FIFO still accepts the key.
        push     = key_ok && (!full || pop) && !flush;
        drop     = key_ok && full && !pop && !flush;

        wr_ptr_d = flush ? '0 : wr_ptr_q + (AW+1)'(push);
        rd_ptr_d = flush ? '0 : rd_ptr_q + (AW+1)'(pop);
        ovf_d    = clr_ovf ? 1'b0 : (ovf_q || drop);

        rdata_d  = rdata_q;
        if (rd_sel) begin
            case (kbd_reg_e'(Addr))
                KBD_DATA: begin
                    rdata_d = '0;
                    if (pop) begin
                        rdata_d[DATA_VALID] = 1'b1;
                        rdata_d[7:0]        = head;
                    end
                end
                KBD_STATUS: rdata_d = kbd_status(empty, full, ST_CNT_W'(count), irq_en, ovf_q);
                KBD_CTRL:   rdata_d = {31'b0, irq_en};
                default:    rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ovf_q    <= 1'b0;
            rdata_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ovf_q    <= ovf_d;
            rdata_q  <= rdata_d;
        end
    end

    assign RData = rdata_q;

`ifdef KBD_IRQ_EN
    logic irq_en_q, irq_en_d;
    logic irq_q;
    logic unused_wdata;

    assign irq_en_d     = wr_ctrl ? WData[CT_IRQEN] : irq_en_q;
    assign unused_wdata = ^WData[31:3];

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            irq_en_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            irq_en_q <= irq_en_d;
            irq_q    <= irq_en_q && (!empty || ovf_q);
        end
    end

    assign irq_en = irq_en_q;
    assign Irq    = irq_q;
`else
    logic unused_wdata;

    assign unused_wdata = ^WData[31:2];
    assign irq_en       = 1'b0;
    assign Irq          = 1'b0;
`endif

endmodule

// File: tb/tb_kbd_rx_fifo.sv
// Self-checking bench for kbd_rx_fifo: vector table plus scoreboarded corner sequences.
// Build with KBD_IRQ_EN defined to also exercise the interrupt path.
module tb_kbd_rx_fifo;

    logic        CLK;
    logic        RST_N;
    logic        KeyValid;
    logic [7:0]  KeyAscii;
    logic        Sel;
    logic        We;
    logic [1:0]  Addr;
    logic [31:0] WData;
    logic [31:0] RData;
    logic        Irq;

    int tests  = 0;
    int failed = 0;

    // Reference model state
    logic [7:0]  model_q[$];
    logic        model_ovf;
    logic        model_irqen;
    logic [31:0] exp_q[$];

    localparam int MDEPTH = 16;

    typedef struct {
        logic        kv;
        logic [7:0]  ka;
        logic        sel;
        logic        we;
        logic [1:0]  addr;
        logic [31:0] wd;
        logic        chk;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[16];

    kbd_rx_fifo dut (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .KeyValid(KeyValid),
        .KeyAscii(KeyAscii),
        .Sel     (Sel),
        .We      (We),
        .Addr    (Addr),
        .WData   (WData),
        .RData   (RData),
        .Irq     (Irq)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end else begin
            $display("[TB] ok   %s: %h", name, act);
        end
    endtask

    function automatic logic [31:0] model_status();
        logic [31:0] s;
        int          n;
        n     = model_q.size();
        s     = '0;
        s[0]  = (n == 0);
        s[1]  = (n == MDEPTH);
        s[8:2] = 7'(n);
        s[14] = model_irqen;
        s[15] = model_ovf;
        return s;
    endfunction

    // One bus/strobe cycle: model predicts, DUT is clocked, reads are scoreboarded.
    task automatic step(input logic kv, input logic [7:0] ka, input logic sel, input logic we,
                        input logic [1:0] addr, input logic [31:0] wd, output logic [31:0] rd);
        logic        is_read, do_pop, do_flush, do_clr;
        logic [31:0] e;
        is_read  = sel && !we;
        do_pop   = is_read && (addr == 2'd0) && (model_q.size() > 0);
        do_flush = sel && we && (addr == 2'd2) && wd[0];
        do_clr   = sel && we && (addr == 2'd2) && wd[1];
        if (is_read) begin
            case (addr)
                2'd0:    e = do_pop ? {1'b1, 23'b0, model_q[0]} : 32'h0;
                2'd1:    e = model_status();
                2'd2:    e = {31'b0, model_irqen};
                default: e = 32'h0;
            endcase
            exp_q.push_back(e);
        end
        if (do_pop) void'(model_q.pop_front());
        if (kv && ka != 8'h00 && !do_flush) begin
            if (model_q.size() < MDEPTH) model_q.push_back(ka);
            else                         model_ovf = 1'b1;
        end
        if (do_clr) model_ovf = 1'b0;
        if (do_flush) model_q.delete();
`ifdef KBD_IRQ_EN
        if (sel && we && addr == 2'd2) model_irqen = wd[2];
`endif
        KeyValid = kv; KeyAscii = ka; Sel = sel; We = we; Addr = addr; WData = wd;
        @(posedge CLK);
        #1;
        KeyValid = 1'b0; KeyAscii = 8'h00; Sel = 1'b0; We = 1'b0; Addr = 2'd0; WData = '0;
        rd = RData;
        if (is_read) begin
            if (exp_q.size() == 0) begin
                check("scoreboard_underflow", 32'h1, 32'h0);
            end else begin
                e = exp_q.pop_front();
                check($sformatf("sb_read_a%0d", addr), rd, e);
            end
        end
    endtask

    task automatic strobe(input logic [7:0] c);
        logic [31:0] rd;
        step(1'b1, c, 1'b0, 1'b0, 2'd0, 32'h0, rd);
    endtask

    task automatic rd_reg(input logic [1:0] a, output logic [31:0] rd);
        step(1'b0, 8'h00, 1'b1, 1'b0, a, 32'h0, rd);
    endtask

    task automatic wr_reg(input logic [1:0] a, input logic [31:0] wd);
        logic [31:0] rd;
        step(1'b0, 8'h00, 1'b1, 1'b1, a, wd, rd);
    endtask

    initial begin
        logic [31:0] rd;
        logic [31:0] held;

        model_ovf = 1'b0; model_irqen = 1'b0;
        KeyValid = 1'b0; KeyAscii = 8'h00; Sel = 1'b0; We = 1'b0; Addr = 2'd0; WData = '0;
        RST_N = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        check("reset_rdata", RData, 32'h0);
        check("reset_irq", {31'b0, Irq}, 32'h0);
        RST_N = 1'b1;
        @(posedge CLK);
        #1;

        //               kv    ka     sel   we    addr  wd            chk   exp
        vecs[0]  = '{1'b1, 8'h61, 1'b0, 1'b0, 2'd0, 32'h0,        1'b0, 32'h0};
        vecs[1]  = '{1'b0, 8'h00, 1'b1, 1'b0, 2'd0, 32'h0,        1'b1, 32'h8000_0061};
        vecs[2]  = '{1'b0, 8'h00, 1'b1, 1'b0, 2'd1, 32'h0,        1'b1, 32'h0000_0001};
        vecs[3]  = '{1'b1, 8'h00, 1'b0, 1'b0, 2'd0, 32'h0,        1'b0, 32'h0};
        vecs[4]  = '{1'b0, 8'h00, 1'b1, 1'b0, 2'd1, 32'h0,        1'b1, 32'h0000_0001};
        vecs[5]  = '{1'b0, 8'h00, 1'b1, 1'b1, 2'd1, 32'hFFFF_FFFF, 1'b0, 32'h0};
        vecs[6]  = '{1'b0, 8'h00, 1'b1, 1'b0, 2'd1, 32'h0,        1'b1, 32'h0000_0001};
        vecs[7]  = '{1'b0, 8'h00, 1'b1, 1'b0, 2'd2, 32'h0,        1'b1, 32'h0};
        vecs[8]  = '{1'b0, 8'h00, 1'b1, 1'b0, 2'd3, 32'h0,        1'b1, 32'h0};
        vecs[9]  = '{1'b0, 8'h00, 1'b1, 1'b1, 2'd3, 32'hFFFF_FFFF, 1'b0, 32'h0};
        vecs[10] = '{1'b1, 8'h62, 1'b0, 1'b0, 2'd0, 32'h0,        1'b0, 32'h0};
        vecs[11] = '{1'b1, 8'h63, 1'b0, 1'b0, 2'd0, 32'h0,        1'b0, 32'h0};
        vecs[12] = '{1'b0, 8'h00, 1'b1, 1'b0, 2'd1, 32'h0,        1'b1, 32'h0000_0008};
        vecs[13] = '{1'b0, 8'h00, 1'b1, 1'b0, 2'd0, 32'h0,        1'b1, 32'h8000_0062};
        vecs[14] = '{1'b0, 8'h00, 1'b1, 1'b0, 2'd0, 32'h0,        1'b1, 32'h8000_0063};
        vecs[15] = '{1'b0, 8'h00, 1'b1, 1'b0, 2'd0, 32'h0,        1'b1, 32'h0};

        for (int i = 0; i < 16; i++) begin
            step(vecs[i].kv, vecs[i].ka, vecs[i].sel, vecs[i].we, vecs[i].addr, vecs[i].wd, rd);
            if (vecs[i].chk) check($sformatf("vec%0d", i), rd, vecs[i].exp);
        end

        // Overflow: 17 strobes into a 16-deep FIFO, then drain in order
        for (int i = 0; i < 17; i++) strobe(8'(8'h31 + i));
        rd_reg(2'd1, rd);
        check("ovf_status", rd, 32'h0000_8042);
        for (int i = 0; i < 16; i++) begin
            rd_reg(2'd0, rd);
            check($sformatf("drain%0d", i), rd, {1'b1, 23'b0, 8'(8'h31 + i)});
        end
        rd_reg(2'd0, rd);
        check("drain_empty", rd, 32'h0);
        rd_reg(2'd1, rd);
        wr_reg(2'd2, 32'h2);
        rd_reg(2'd1, rd);
        check("clrovf_status", rd, 32'h0000_0001);

        // Full FIFO, push and pop in the same cycle
        for (int i = 0; i < 16; i++) strobe(8'(8'h41 + i));
        step(1'b1, 8'h7A, 1'b1, 1'b0, 2'd0, 32'h0, rd);
        check("full_pushpop_data", rd, 32'h8000_0041);
        rd_reg(2'd1, rd);
        check("full_pushpop_status", rd, 32'h0000_0042);
        for (int i = 0; i < 16; i++) rd_reg(2'd0, rd);
        check("z_read_last", rd, 32'h8000_007A);
        held = rd;
        repeat (3) strobe(8'h00);
        check("rdata_hold", RData, held);

        // Flush with ClrOverflow after an overflow
        for (int i = 0; i < 17; i++) strobe(8'(8'h61 + i));
        wr_reg(2'd2, 32'h3);
        rd_reg(2'd1, rd);
        check("flush_status", rd, 32'h0000_0001);
        rd_reg(2'd0, rd);
        check("flush_data", rd, 32'h0);

        // ClrOverflow wins over a same-cycle overflow; flush wins over a same-cycle push
        for (int i = 0; i < 16; i++) strobe(8'(8'h30 + i));
        step(1'b1, 8'h21, 1'b1, 1'b1, 2'd2, 32'h2, rd);
        rd_reg(2'd1, rd);
        check("clr_wins_status", rd, 32'h0000_0042);
        step(1'b1, 8'h78, 1'b1, 1'b1, 2'd2, 32'h1, rd);
        rd_reg(2'd1, rd);
        check("flush_wins_status", rd, 32'h0000_0001);

        // Interrupt enable / level interrupt
        wr_reg(2'd2, 32'h4);
        rd_reg(2'd2, rd);
        strobe(8'h71);
`ifdef KBD_IRQ_EN
        for (int i = 0; i < 3 && Irq !== 1'b1; i++) begin
            @(posedge CLK);
            #1;
        end
        check("irq_set", {31'b0, Irq}, 32'h1);
        rd_reg(2'd0, rd);
        for (int i = 0; i < 3 && Irq !== 1'b0; i++) begin
            @(posedge CLK);
            #1;
        end
        check("irq_clear", {31'b0, Irq}, 32'h0);
`else
        strobe(8'h00);
        check("irq_tied", {31'b0, Irq}, 32'h0);
        rd_reg(2'd0, rd);
`endif
        wr_reg(2'd2, 32'h0);

        // Asynchronous reset mid-burst
        strobe(8'h70);
        strobe(8'h71);
        rd_reg(2'd1, rd);
        KeyValid = 1'b1; KeyAscii = 8'h72;
        #2;
        RST_N = 1'b0;
        #1;
        check("async_rst_rdata", RData, 32'h0);
        check("async_rst_irq", {31'b0, Irq}, 32'h0);
        @(posedge CLK);
        #1;
        KeyValid = 1'b0; KeyAscii = 8'h00;
        RST_N = 1'b1;
        model_q.delete(); model_ovf = 1'b0; model_irqen = 1'b0;
        @(posedge CLK);
        #1;
        rd_reg(2'd1, rd);
        check("post_rst_status", rd, 32'h0000_0001);
        rd_reg(2'd0, rd);
        check("post_rst_data", rd, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

endmodule
